// File: rtl/flappy_pkg.sv
// Shared state type, screen geometry and LFSR constants for the flappy game controller.
package flappy_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, DEAD} game_state_t;

    localparam logic [9:0]  SCREEN_H     = 10'd480;
    localparam logic [8:0]  BIRD_START   = 9'd265;
    localparam logic [9:0]  PIPE_START   = 10'd600;
    localparam logic [8:0]  HOLE_DEFAULT = 9'd165;
    localparam logic [8:0]  HOLE_OFFSET  = 9'd37;
    localparam logic [9:0]  COLL_X_MIN   = 10'd50;
    localparam logic [9:0]  COLL_X_MAX   = 10'd200;
    localparam logic [9:0]  GAP_LO       = 10'd50;
    localparam logic [9:0]  GAP_HI       = 10'd150;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    // Galois right-shift mask for taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/flappy_frame_tick.sv
// Registers v_sync and emits a one-cycle tick when the registered copy falls.
module flappy_frame_tick (
    input  logic clock,
    input  logic reset,
    input  logic v_sync,
    output logic tick
);

    logic sync_q;
    logic sync_d;

    // Clearing the history on reset discards any falling edge already in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            sync_d <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= v_sync;
            sync_d <= sync_q;
            tick   <= sync_d & ~sync_q;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game-state controller: bird physics, N scrolling pipes, collision, scoring.
// Define FLAPPY_HISCORE_EN to add the high_score output and its register.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES    = 2,
    parameter int PIPE_SPACING = 372,
    parameter int PIPE_SPEED   = 4,
    parameter int FLAP_VEL     = -11,
    parameter int MAX_FALL     = 8,
    parameter int DEAD_FRAMES  = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    v_sync,
    input  logic                    button,
    output logic [8:0]              bird_pos,
    output logic [10*NUM_PIPES-1:0] pipe_pos,
    output logic [9*NUM_PIPES-1:0]  hole_pos,
    output logic [7:0]              score,
`ifdef FLAPPY_HISCORE_EN
    output logic [7:0]              high_score,
`endif
    output logic                    game_over,
    output logic                    playing
);

    localparam int                     LOCK_W   = $clog2(DEAD_FRAMES + 1);
    localparam logic [LOCK_W-1:0]      LOCK_MAX = LOCK_W'(DEAD_FRAMES);
    localparam logic signed [8:0]      FLAP_V   = 9'(FLAP_VEL);
    localparam logic signed [8:0]      MAX_V    = 9'(MAX_FALL);
    localparam logic [9:0]             SPEED    = 10'(PIPE_SPEED);
    localparam logic [9:0]             WRAP_POS = 10'(NUM_PIPES * PIPE_SPACING);

    function automatic logic [9:0] pipe_start(input int idx);
        return PIPE_START + 10'(idx * PIPE_SPACING);
    endfunction

    game_state_t         state_q, state_n;
    logic [8:0]          bird_q, bird_n;
    logic signed [8:0]   vel_q, vel_n;
    logic [9:0]          pipe_q [NUM_PIPES];
    logic [9:0]          pipe_n [NUM_PIPES];
    logic [8:0]          hole_q [NUM_PIPES];
    logic [8:0]          hole_n [NUM_PIPES];
    logic [7:0]          score_q, score_n;
    logic [LOCK_W-1:0]   lockout_q, lockout_n;
    logic                latch_q, latch_n;
    logic [15:0]         lfsr_q;
    logic                tick;
    logic                flap;
    logic                collide;
    logic [10:0]         bird_sum;

    flappy_frame_tick u_frame_tick (
        .clock  (clock),
        .reset  (reset),
        .v_sync (v_sync),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bird_q    <= BIRD_START;
            vel_q     <= '0;
            score_q   <= '0;
            lockout_q <= '0;
            latch_q   <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_q[i] <= pipe_start(i);
                hole_q[i] <= HOLE_DEFAULT;
            end
        end else begin
            state_q   <= state_n;
            bird_q    <= bird_n;
            vel_q     <= vel_n;
            score_q   <= score_n;
            lockout_q <= lockout_n;
            latch_q   <= latch_n;
            lfsr_q    <= lfsr_next(lfsr_q);
            pipe_q    <= pipe_n;
            hole_q    <= hole_n;
        end
    end

    // Everything below only moves on a frame tick; collision uses the pre-update values
    always_comb begin
        state_n   = state_q;
        bird_n    = bird_q;
        vel_n     = vel_q;
        score_n   = score_q;
        lockout_n = lockout_q;
        latch_n   = latch_q;
        pipe_n    = pipe_q;
        hole_n    = hole_q;
        flap      = 1'b0;
        collide   = 1'b0;
        bird_sum  = '0;
        if (tick) begin
            flap    = ~button & ~latch_q;
            latch_n = ~button;
            case (state_q)
                IDLE: begin
                    if (flap) begin
                        state_n = PLAY;
                        vel_n   = FLAP_V;
                    end
                end
                PLAY: begin
                    collide = ({1'b0, bird_q} > SCREEN_H);
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if (pipe_q[i] > COLL_X_MIN && pipe_q[i] < COLL_X_MAX &&
                            !(({1'b0, bird_q} > {1'b0, hole_q[i]} + GAP_LO) &&
                              ({1'b0, bird_q} < {1'b0, hole_q[i]} + GAP_HI)))
                            collide = 1'b1;
                    end
                    bird_sum = {2'b00, bird_q} + {{2{vel_q[8]}}, vel_q};
                    bird_n   = bird_sum[10] ? 9'd0 : bird_sum[8:0];
                    if (flap)
                        vel_n = FLAP_V;
                    else if (vel_q >= MAX_V)
                        vel_n = MAX_V;
                    else
                        vel_n = vel_q + 9'sd1;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if (pipe_q[i] < SPEED) begin
                            pipe_n[i] = WRAP_POS;
                            hole_n[i] = {1'b0, lfsr_q[7:0]} + HOLE_OFFSET;
                            if (score_n != 8'd255)
                                score_n = score_n + 8'd1;
                        end else begin
                            pipe_n[i] = pipe_q[i] - SPEED;
                        end
                    end
                    if (collide)
                        state_n = DEAD;
                end
                DEAD: begin
                    if (flap && lockout_q == LOCK_MAX) begin
                        state_n   = IDLE;
                        bird_n    = BIRD_START;
                        vel_n     = '0;
                        score_n   = '0;
                        lockout_n = '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            pipe_n[i] = pipe_start(i);
                            hole_n[i] = HOLE_DEFAULT;
                        end
                    end else if (lockout_q != LOCK_MAX) begin
                        lockout_n = lockout_q + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef FLAPPY_HISCORE_EN
    logic [7:0] hiscore_q;

    // Survives restarts; only reset clears it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            hiscore_q <= '0;
        else if (state_q == PLAY && state_n == DEAD && score_q > hiscore_q)
            hiscore_q <= score_q;
    end

    assign high_score = hiscore_q;
`endif

    always_comb begin
        pipe_pos = '0;
        hole_pos = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_pos[10*i +: 10] = pipe_q[i];
            hole_pos[9*i +: 9]   = hole_q[i];
        end
    end

    assign bird_pos  = bird_q;
    assign score     = score_q;
    assign game_over = (state_q == DEAD);
    assign playing   = (state_q == PLAY);

endmodule
